// File: rtl/jk_button_conditioner.sv
// Two-channel button conditioner: 2-flop synchronizer, counter debouncer and
// rising-edge pulse per channel. Channel 0 is J, channel 1 is K.
module jk_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_J,
   input  logic BTN_K,
   output logic J,
   output logic K,
   output logic J_LVL,
   output logic K_LVL
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         s1_q, s1_d;
   logic [1:0]         s2_q, s2_d;
   logic [1:0]         lvl_q, lvl_d;
   logic [1:0]         pulse_q, pulse_d;
   logic [1:0][CW-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d    = {BTN_K, BTN_J};
      s2_d    = s1_q;
      lvl_d   = lvl_q;
      cnt_d   = cnt_q;
      pulse_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_TC) begin
            // Accept the new level; only a 0->1 acceptance produces a pulse.
            lvl_d[i]   = s2_q[i];
            cnt_d[i]   = '0;
            pulse_d[i] = s2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q    <= '0;
         s2_q    <= '0;
         lvl_q   <= '0;
         pulse_q <= '0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         lvl_q   <= lvl_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign J     = pulse_q[0];
   assign K     = pulse_q[1];
   assign J_LVL = lvl_q[0];
   assign K_LVL = lvl_q[1];

endmodule
